// File: rtl/arm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : arm_pkg                                                          |
// | Brief   : Shared NZCV flag indices, condition codes and flag helpers.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package arm_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam nzcv_t C_FLAGS_RESET = 4'b0000;

    function automatic nzcv_t pack_nzcv(input logic n, input logic z,
                                        input logic c, input logic v);
        nzcv_t f;
        f         = C_FLAGS_RESET;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage : arm_pkg
`default_nettype wire

// File: rtl/flag_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : flag_gen                                                         |
// | Brief   : Combinational NZCV derivation from the EX-stage ALU result.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module flag_gen
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              ex_logical_i,
    input  logic              alu_c_i,
    input  logic              alu_v_i,
    input  logic              shifter_c_i,
    input  logic              v_prev_i,
    output logic [3:0]        ex_flags_o
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    // Logical ops take carry from the shifter and leave V untouched.
    assign w_n = alu_result_i[DATA_W-1];
    assign w_z = (alu_result_i == '0);
    assign w_c = ex_logical_i ? shifter_c_i : alu_c_i;
    assign w_v = ex_logical_i ? v_prev_i    : alu_v_i;

    assign ex_flags_o = pack_nzcv(w_n, w_z, w_c, w_v);

endmodule : flag_gen
`default_nettype wire

// File: rtl/status_register_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : status_register_unit                                             |
// | Brief   : NZCV status register, ID-side bypass and flag-hazard tracking.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module status_register_unit
    import arm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter bit BYPASS   = 1'b1,
    parameter int MAX_INFL = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_issue_s,
    input  logic              id_uses_cond,
    input  logic              ex_valid,
    input  logic              ex_s,
    input  logic              ex_logical,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              shifter_c,
    input  logic              msr_en,
    input  logic [3:0]        msr_flags,
    output logic [3:0]        status_ID,
    output logic [3:0]        status_q,
    output logic              flag_hazard,
    output logic [1:0]        infl_cnt
);

    localparam logic [1:0] C_CNT_MAX = 2'(MAX_INFL);

    nzcv_t      w_ex_flags;
    nzcv_t      status_d;
    logic       w_ex_wr;
    logic       w_flag_wr;
    logic       w_inc;
    logic       w_dec;
    logic       w_pending;
    logic [1:0] infl_cnt_d;
    nzcv_t      status_r_q;
    logic [1:0] infl_cnt_q;

    flag_gen #(
        .DATA_W (DATA_W)
    ) u_flag_gen (
        .alu_result_i (alu_result),
        .ex_logical_i (ex_logical),
        .alu_c_i      (alu_c),
        .alu_v_i      (alu_v),
        .shifter_c_i  (shifter_c),
        .v_prev_i     (status_r_q[FLAG_V]),
        .ex_flags_o   (w_ex_flags)
    );

    assign w_ex_wr   = ex_valid & ex_s;
    assign w_flag_wr = msr_en | w_ex_wr;

    // Direct writes outrank the EX result; flush never blocks the EX commit.
    always_comb begin
        status_d = status_r_q;
        if (msr_en) begin
            status_d = msr_flags;
        end else if (w_ex_wr) begin
            status_d = w_ex_flags;
        end
    end

    assign w_inc = id_issue_s & ~flush;
    assign w_dec = w_ex_wr;

    always_comb begin
        infl_cnt_d = infl_cnt_q;
        if (flush) begin
            infl_cnt_d = 2'd0;
        end else if (w_inc && !w_dec) begin
            if (infl_cnt_q < C_CNT_MAX) begin
                infl_cnt_d = infl_cnt_q + 2'd1;
            end
        end else if (w_dec && !w_inc) begin
            if (infl_cnt_q != 2'd0) begin
                infl_cnt_d = infl_cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_r_q <= C_FLAGS_RESET;
            infl_cnt_q <= 2'd0;
        end else if (!freeze) begin
            status_r_q <= status_d;
            infl_cnt_q <= infl_cnt_d;
        end
    end

    // With bypass, the instruction currently in EX resolves its own flags,
    // so only the S-instructions behind it still block ID.
    generate
        if (BYPASS) begin : g_bypass
            assign w_pending = (infl_cnt_q > {1'b0, w_ex_wr});
            assign status_ID = rst ? C_FLAGS_RESET :
                               (w_flag_wr ? status_d : status_r_q);
        end else begin : g_no_bypass
            assign w_pending = (infl_cnt_q != 2'd0);
            assign status_ID = rst ? C_FLAGS_RESET : status_r_q;
        end
    endgenerate

    assign flag_hazard = ~rst & id_uses_cond & w_pending;
    assign status_q    = status_r_q;
    assign infl_cnt    = infl_cnt_q;

endmodule : status_register_unit
`default_nettype wire

// File: tb/tb_status_register_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_status_register_unit                                          |
// | Brief   : Directed self-checking bench for status_register_unit.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_status_register_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        id_issue_s;
    logic        id_uses_cond;
    logic        ex_valid;
    logic        ex_s;
    logic        ex_logical;
    logic [31:0] alu_result;
    logic        alu_c;
    logic        alu_v;
    logic        shifter_c;
    logic        msr_en;
    logic [3:0]  msr_flags;
    logic [3:0]  status_ID;
    logic [3:0]  status_q;
    logic        flag_hazard;
    logic [1:0]  infl_cnt;

    int n_cmp;
    int n_bad;

    status_register_unit #(
        .DATA_W   (32),
        .BYPASS   (1'b1),
        .MAX_INFL (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .id_issue_s   (id_issue_s),
        .id_uses_cond (id_uses_cond),
        .ex_valid     (ex_valid),
        .ex_s         (ex_s),
        .ex_logical   (ex_logical),
        .alu_result   (alu_result),
        .alu_c        (alu_c),
        .alu_v        (alu_v),
        .shifter_c    (shifter_c),
        .msr_en       (msr_en),
        .msr_flags    (msr_flags),
        .status_ID    (status_ID),
        .status_q     (status_q),
        .flag_hazard  (flag_hazard),
        .infl_cnt     (infl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the edge; outputs are read 1 ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        freeze       = 1'b0;
        flush        = 1'b0;
        id_issue_s   = 1'b0;
        id_uses_cond = 1'b0;
        ex_valid     = 1'b0;
        ex_s         = 1'b0;
        ex_logical   = 1'b0;
        alu_result   = 32'h0000_0000;
        alu_c        = 1'b0;
        alu_v        = 1'b0;
        shifter_c    = 1'b0;
        msr_en       = 1'b0;
        msr_flags    = 4'b0000;
    endtask

    task automatic test_reset;
        idle();
        rst          = 1'b1;
        ex_valid     = 1'b1;
        ex_s         = 1'b1;
        id_issue_s   = 1'b1;
        id_uses_cond = 1'b1;
        alu_result   = 32'h8000_0000;
        alu_c        = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (status_q !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_status_q: got %b expected 0000", status_q);
        end
        n_cmp++;
        if (infl_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_infl_cnt: got %0d expected 0", infl_cnt);
        end
        n_cmp++;
        if (flag_hazard !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hazard: got %b expected 0", flag_hazard);
        end
        n_cmp++;
        if (status_ID !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_status_ID: got %b expected 0000", status_ID);
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_arith;
        ex_valid   = 1'b1;
        ex_s       = 1'b1;
        ex_logical = 1'b0;
        alu_result = 32'h0000_0000;
        alu_c      = 1'b1;
        alu_v      = 1'b0;
        #1;
        n_cmp++;
        if (status_ID !== 4'b0110) begin
            n_bad++;
            $display("FAIL arith_bypass: got %b expected 0110", status_ID);
        end
        tick();
        n_cmp++;
        if (status_q !== 4'b0110) begin
            n_bad++;
            $display("FAIL arith_status_q: got %b expected 0110", status_q);
        end
        idle();
        #1;
        n_cmp++;
        if (status_ID !== 4'b0110) begin
            n_bad++;
            $display("FAIL arith_status_ID_hold: got %b expected 0110", status_ID);
        end
    endtask

    task automatic test_logical;
        idle();
        msr_en    = 1'b1;
        msr_flags = 4'b0001;
        tick();
        idle();
        ex_valid   = 1'b1;
        ex_s       = 1'b1;
        ex_logical = 1'b1;
        alu_result = 32'h8000_0000;
        shifter_c  = 1'b0;
        alu_c      = 1'b1;
        alu_v      = 1'b0;
        #1;
        n_cmp++;
        if (status_ID !== 4'b1001) begin
            n_bad++;
            $display("FAIL logical_bypass: got %b expected 1001", status_ID);
        end
        tick();
        n_cmp++;
        if (status_q !== 4'b1001) begin
            n_bad++;
            $display("FAIL logical_status_q: got %b expected 1001", status_q);
        end
        idle();
    endtask

    task automatic test_priority;
        idle();
        msr_en     = 1'b1;
        msr_flags  = 4'b1111;
        ex_valid   = 1'b1;
        ex_s       = 1'b1;
        alu_result = 32'h0000_0001;
        #1;
        n_cmp++;
        if (status_ID !== 4'b1111) begin
            n_bad++;
            $display("FAIL prio_bypass: got %b expected 1111", status_ID);
        end
        tick();
        n_cmp++;
        if (status_q !== 4'b1111) begin
            n_bad++;
            $display("FAIL prio_status_q: got %b expected 1111", status_q);
        end
        n_cmp++;
        if (infl_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL prio_cnt_floor: got %0d expected 0", infl_cnt);
        end
        idle();
    endtask

    task automatic test_counter;
        idle();
        id_issue_s = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (infl_cnt !== 2'd2) begin
            n_bad++;
            $display("FAIL cnt_two_issues: got %0d expected 2", infl_cnt);
        end
        id_issue_s   = 1'b0;
        id_uses_cond = 1'b1;
        #1;
        n_cmp++;
        if (flag_hazard !== 1'b1) begin
            n_bad++;
            $display("FAIL hazard_pending2: got %b expected 1", flag_hazard);
        end
        ex_valid   = 1'b1;
        ex_s       = 1'b1;
        alu_result = 32'h0000_0005;
        #1;
        n_cmp++;
        if (flag_hazard !== 1'b1) begin
            n_bad++;
            $display("FAIL hazard_2_vs_ex: got %b expected 1", flag_hazard);
        end
        tick();
        n_cmp++;
        if (infl_cnt !== 2'd1) begin
            n_bad++;
            $display("FAIL cnt_after_commit: got %0d expected 1", infl_cnt);
        end
        n_cmp++;
        if (flag_hazard !== 1'b0) begin
            n_bad++;
            $display("FAIL hazard_1_vs_ex: got %b expected 0", flag_hazard);
        end
        ex_valid = 1'b0;
        #1;
        n_cmp++;
        if (flag_hazard !== 1'b1) begin
            n_bad++;
            $display("FAIL hazard_1_no_ex: got %b expected 1", flag_hazard);
        end
        id_uses_cond = 1'b0;
        #1;
        n_cmp++;
        if (flag_hazard !== 1'b0) begin
            n_bad++;
            $display("FAIL hazard_uncond: got %b expected 0", flag_hazard);
        end
        id_issue_s = 1'b1;
        ex_valid   = 1'b1;
        tick();
        n_cmp++;
        if (infl_cnt !== 2'd1) begin
            n_bad++;
            $display("FAIL cnt_inc_dec_hold: got %0d expected 1", infl_cnt);
        end
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        n_cmp++;
        if (infl_cnt !== 2'd3) begin
            n_bad++;
            $display("FAIL cnt_saturate: got %0d expected 3", infl_cnt);
        end
        idle();
    endtask

    task automatic test_flush_freeze;
        idle();
        ex_valid   = 1'b1;
        ex_s       = 1'b1;
        alu_result = 32'h0000_0000;
        alu_c      = 1'b1;
        tick();
        idle();
        msr_en    = 1'b1;
        msr_flags = 4'b1110;
        tick();
        n_cmp++;
        if (infl_cnt !== 2'd2) begin
            n_bad++;
            $display("FAIL ff_cnt_pre: got %0d expected 2", infl_cnt);
        end
        n_cmp++;
        if (status_q !== 4'b1110) begin
            n_bad++;
            $display("FAIL ff_msr_load: got %b expected 1110", status_q);
        end
        idle();
        flush      = 1'b1;
        id_issue_s = 1'b1;
        ex_valid   = 1'b1;
        ex_s       = 1'b1;
        alu_result = 32'h7FFF_FFFF;
        alu_c      = 1'b0;
        alu_v      = 1'b1;
        tick();
        n_cmp++;
        if (status_q !== 4'b0001) begin
            n_bad++;
            $display("FAIL flush_commit: got %b expected 0001", status_q);
        end
        n_cmp++;
        if (infl_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL flush_cnt: got %0d expected 0", infl_cnt);
        end
        idle();
        id_issue_s = 1'b1;
        tick();
        idle();
        freeze     = 1'b1;
        id_issue_s = 1'b1;
        ex_valid   = 1'b1;
        ex_s       = 1'b1;
        alu_result = 32'h0000_0000;
        alu_c      = 1'b1;
        #1;
        n_cmp++;
        if (status_ID !== 4'b0110) begin
            n_bad++;
            $display("FAIL freeze_bypass: got %b expected 0110", status_ID);
        end
        tick();
        n_cmp++;
        if (status_q !== 4'b0001) begin
            n_bad++;
            $display("FAIL freeze_status_q: got %b expected 0001", status_q);
        end
        n_cmp++;
        if (infl_cnt !== 2'd1) begin
            n_bad++;
            $display("FAIL freeze_cnt: got %0d expected 1", infl_cnt);
        end
    endtask

    task automatic test_rst_mid;
        freeze       = 1'b1;
        flush        = 1'b1;
        msr_en       = 1'b1;
        msr_flags    = 4'b1010;
        id_uses_cond = 1'b1;
        ex_valid     = 1'b0;
        rst          = 1'b1;
        #1;
        n_cmp++;
        if (flag_hazard !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_hazard_mask: got %b expected 0", flag_hazard);
        end
        n_cmp++;
        if (status_ID !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_status_ID: got %b expected 0000", status_ID);
        end
        tick();
        n_cmp++;
        if (status_q !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_mid_status_q: got %b expected 0000", status_q);
        end
        n_cmp++;
        if (infl_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_mid_cnt: got %0d expected 0", infl_cnt);
        end
        rst = 1'b0;
        idle();
        id_uses_cond = 1'b1;
        #1;
        n_cmp++;
        if (flag_hazard !== 1'b0) begin
            n_bad++;
            $display("FAIL post_rst_hazard: got %b expected 0", flag_hazard);
        end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle();
        #2;
        test_reset();
        test_arith();
        test_logical();
        test_priority();
        test_counter();
        test_flush_freeze();
        test_rst_mid();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_status_register_unit
`default_nettype wire
